// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: command codes and counter width.
package md_unit_pkg;

    localparam int unsigned MD_CNT_W = 4;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    // True for the four ops that run through the latency counter.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit product and quotient/remainder for signed and unsigned mult/div.
module md_arith
    import md_unit_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div0_o
);

    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic        sgn;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Divide works on magnitudes, so 0x80000000 / -1 needs no overflow special case.
    always_comb begin
        prod_u = {32'b0, a_i} * {32'b0, b_i};
        // Sign-extended operands multiplied modulo 2^64 yield the signed product.
        prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
        sgn    = (op_i == MD_DIV);
        a_mag  = (sgn && a_i[31]) ? (~a_i + 32'd1) : a_i;
        b_mag  = (sgn && b_i[31]) ? (~b_i + 32'd1) : b_i;
        q_mag  = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
        r_mag  = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
        quot   = (sgn && (a_i[31] ^ b_i[31])) ? (~q_mag + 32'd1) : q_mag;
        rem    = (sgn && a_i[31]) ? (~r_mag + 32'd1) : r_mag;
        div0_o = is_div(op_i) && (b_i == 32'd0);
        hi_o   = 32'd0;
        lo_o   = 32'd0;
        case (op_i)
            MD_MULT:  begin hi_o = prod_s[63:32]; lo_o = prod_s[31:0]; end
            MD_MULTU: begin hi_o = prod_u[63:32]; lo_o = prod_u[31:0]; end
            MD_DIV,
            MD_DIVU:  begin hi_o = rem;           lo_o = quot;         end
            default:  begin hi_o = 32'd0;         lo_o = 32'd0;        end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: latency counter, HI/LO ownership and MD-class stall.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_sel,
    input  logic        d_is_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] rd_data
);

    localparam logic [MD_CNT_W-1:0] MultCnt = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DivCnt  = MD_CNT_W'(DIV_CYCLES);

    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]         hi_q, hi_d;
    logic [31:0]         lo_q, lo_d;
    logic [31:0]         p_hi_q, p_hi_d;
    logic [31:0]         p_lo_q, p_lo_d;
    // Cleared for divide-by-zero so HI/LO keep their prior values at completion.
    logic                p_upd_q, p_upd_d;

    logic [31:0] ar_hi;
    logic [31:0] ar_lo;
    logic        ar_div0;
    logic        accept;
    logic        op_md;

    md_arith u_arith (
        .op_i   (md_op),
        .a_i    (rs_val),
        .b_i    (rt_val),
        .hi_o   (ar_hi),
        .lo_o   (ar_lo),
        .div0_o (ar_div0)
    );

    // Outputs and command decode; start while busy is dropped.
    always_comb begin
        busy     = (cnt_q != '0);
        op_md    = is_muldiv(md_op);
        accept   = start && !busy;
        md_stall = d_is_md && (busy || (start && op_md));
        rd_data  = rd_sel ? hi_q : lo_q;
    end

    // Next-state: launch, count down, commit pending result on the 1->0 step.
    always_comb begin
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        p_upd_d = p_upd_q;
        if (accept && op_md) begin
            cnt_d   = is_div(md_op) ? DivCnt : MultCnt;
            p_hi_d  = ar_hi;
            p_lo_d  = ar_lo;
            p_upd_d = !ar_div0;
        end else if (busy) begin
            cnt_d = cnt_q - MD_CNT_W'(1);
            if ((cnt_q == MD_CNT_W'(1)) && p_upd_q) begin
                hi_d = p_hi_q;
                lo_d = p_lo_q;
            end
        end
        if (accept && (md_op == MD_MTHI)) hi_d = rs_val;
        if (accept && (md_op == MD_MTLO)) lo_d = rs_val;
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            p_upd_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            p_upd_q <= p_upd_d;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit against a plain-arithmetic HI/LO model.
module tb_md_unit;

    localparam int unsigned MultN = 5;
    localparam int unsigned DivN  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        rd_sel = 1'b0;
    logic        d_is_md = 1'b0;
    logic        busy;
    logic        md_stall;
    logic [31:0] rd_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    md_unit #(
        .MULT_CYCLES (MultN),
        .DIV_CYCLES  (DivN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .rd_sel   (rd_sel),
        .d_is_md  (d_is_md),
        .busy     (busy),
        .md_stall (md_stall),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    // The pipeline must never present start while the unit is busy.
    always @(posedge clk) begin
        if (reset && start) begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL start_while_busy: busy=%b required 0", busy);
            end
        end
    end

    // Reference: results from 64-bit integer arithmetic on the raw operands.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l);
        longint          sp, sa, sb, q, r;
        longint unsigned up, ua, ub, uq, ur;
        case (op)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                h = sp[63:32]; l = sp[31:0];
            end
            3'd1: begin
                ua = {32'b0, a}; ub = {32'b0, b}; up = ua * ub;
                h = up[63:32]; l = up[31:0];
            end
            3'd2: if (b != 0) begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                q = sa / sb; r = sa % sb;
                h = r[31:0]; l = q[31:0];
            end
            3'd3: if (b != 0) begin
                ua = {32'b0, a}; ub = {32'b0, b}; uq = ua / ub; ur = ua % ub;
                h = ur[31:0]; l = uq[31:0];
            end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endfunction

    task automatic check_hilo(input string name);
        rd_sel = 1'b1; #1;
        checks++;
        if (rd_data !== hi_m) begin
            errors++;
            $display("FAIL %s_hi: got %h required %h", name, rd_data, hi_m);
        end
        rd_sel = 1'b0; #1;
        checks++;
        if (rd_data !== lo_m) begin
            errors++;
            $display("FAIL %s_lo: got %h required %h", name, rd_data, lo_m);
        end
    endtask

    // Issue one command; returns at the negedge of the first cycle with busy low again.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic dmd, input bit b2b, input string name);
        logic        md;
        int          n;
        int          exp_n;
        logic [31:0] old_lo;
        md     = (op <= 3'd3);
        exp_n  = (op >= 3'd2) ? DivN : MultN;
        old_lo = lo_m;
        if (!b2b) @(negedge clk);
        md_op = op; rs_val = a; rt_val = b; d_is_md = dmd; start = 1'b1; rd_sel = 1'b0;
        #1;
        checks++;
        if (md_stall !== (dmd & md)) begin
            errors++;
            $display("FAIL %s_stall_T: got %b required %b", name, md_stall, dmd & md);
        end
        @(negedge clk);
        start = 1'b0;
        model(op, a, b, hi_m, lo_m);
        n = 0;
        if (md) begin
            while (busy === 1'b1 && n < 20) begin
                if (n == 0) begin
                    checks++;
                    if (rd_data !== old_lo) begin
                        errors++;
                        $display("FAIL %s_lo_early: got %h required %h", name, rd_data, old_lo);
                    end
                end
                checks++;
                if (md_stall !== dmd) begin
                    errors++;
                    $display("FAIL %s_stall_busy: got %b required %b", name, md_stall, dmd);
                end
                n++;
                @(negedge clk);
            end
            checks++;
            if (n != exp_n) begin
                errors++;
                $display("FAIL %s_busy_len: got %0d required %0d", name, n, exp_n);
            end
        end
        checks++;
        if (busy !== 1'b0 || md_stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b stall=%b required 0 0", name, busy, md_stall);
        end
        check_hilo(name);
    endtask

    task automatic test_reset;
        d_is_md = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b0 || md_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b stall=%b required 0 0", busy, md_stall);
        end
        check_hilo("reset");
        @(negedge clk);
        reset = 1'b1;
        d_is_md = 1'b0;
    endtask

    task automatic test_mult;
        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, "mult");
        checks++;
        if (hi_m !== 32'hFFFF_FFFF || lo_m !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mult_model: got %h_%h required ffffffff_fffffffa", hi_m, lo_m);
        end
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu");
    endtask

    task automatic test_div;
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_neg");
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
        do_op(3'd2, 32'd5, 32'd0, 1'b0, 1'b0, "div_zero");
        do_op(3'd3, 32'd5, 32'd0, 1'b0, 1'b0, "divu_zero");
    endtask

    task automatic test_mthi_divu;
        do_op(3'd4, 32'h0000_1234, 32'd0, 1'b0, 1'b0, "mthi");
        do_op(3'd5, 32'hCAFE_0001, 32'd0, 1'b1, 1'b0, "mtlo");
        do_op(3'd3, 32'hFFFF_FFF0, 32'd7, 1'b1, 1'b0, "divu_stall");
    endtask

    task automatic test_back_to_back;
        do_op(3'd0, 32'd12345, 32'hFFFF_0000, 1'b1, 1'b0, "b2b_a");
        do_op(3'd2, 32'd1000, 32'hFFFF_FFFD, 1'b1, 1'b1, "b2b_b");
        do_op(3'd1, 32'h8000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, "b2b_c");
    endtask

    task automatic test_reset_mid_op;
        @(negedge clk);
        md_op = 3'd2; rs_val = 32'd100; rt_val = 32'd7; d_is_md = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        hi_m = '0; lo_m = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || md_stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_flags: busy=%b stall=%b required 0 0", busy, md_stall);
        end
        check_hilo("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        d_is_md = 1'b0;
        do_op(3'd0, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0, 1'b0, "post_rst_mult");
    endtask

    task automatic test_alu_no_stall;
        do_op(3'd3, 32'd99, 32'd10, 1'b0, 1'b0, "alu_nostall");
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 20; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_divu();
        test_back_to_back();
        test_reset_mid_op();
        test_alu_no_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit with its own sequencing controller for the MIPS pipeline, sitting in the EX stage next to the ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from EX, runs a latency counter, owns the HI/LO registers, and raises a stall request so that later multiply/divide-class instructions in ID wait while it is busy. Its stall output is ORed with the register-hazard stall in the top-level hazard logic.

## Interface

Parameters:
- MULT_CYCLES, default 5: busy cycles for MULT/MULTU, must be 1..15
- DIV_CYCLES, default 10: busy cycles for DIV/DIVU, must be 1..15

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  EX-stage command valid, single-cycle pulse
- md_op  in  3  command code: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- rd_sel  in  1  read select: 0 = LO, 1 = HI
- d_is_md  in  1  the ID-stage instruction is MD-class (mult/div/mfhi/mflo/mthi/mtlo)
- busy  out  1  an operation is in progress
- md_stall  out  1  stall request to the hazard unit
- rd_data  out  32  HI or LO, selected by rd_sel, feeding EX result (mfhi/mflo)

The clock and reset ports are named clk and reset. There is one clock. reset is asynchronous and active-low.

## Operation

- State: IDLE or RUN, encoded as busy = (cnt != 0), with a 4-bit down-counter cnt. Pending result registers are p_hi and p_lo.
- In IDLE with start and a MULT/MULTU/DIV/DIVU op:
  - Compute the result into p_hi/p_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
- In IDLE with start and MTHI/MTLO: write rs_val into HI or LO at that edge. cnt stays 0.
- In RUN: cnt decrements every cycle. On the edge where cnt goes 1→0, HI<=p_hi and LO<=p_lo.
- start while busy is ignored. The stall logic guarantees this never happens, and the bench asserts it.
- MULT: {HI,LO} = signed 64-bit product. MULTU: the unsigned product.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero: the full DIV_CYCLES busy period still runs, and HI/LO keep their prior values.
- md_stall = d_is_md & (busy | (start & md_op is mult/div)). This is combinational, so the instruction directly behind a mult/div already stalls.
- rd_data is combinational from the HI/LO registers. It is not bypassed from an in-flight MTHI/MTLO; the one-cycle ordering is covered by the pipeline.

## Timing

- Reset values: HI=0, LO=0, p_hi=0, p_lo=0, cnt=0, so busy=0, md_stall=0, rd_data=0.
- Reset asserted mid-operation aborts it immediately. HI/LO return to 0 and busy drops asynchronously.
- A mult/div with start in cycle T:
  - busy is high in cycles T+1 .. T+N (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO hold new values and busy=0 from cycle T+N+1.
  - md_stall can be high from cycle T through T+N.
- MTHI/MTLO with start in cycle T: the new value is readable from cycle T+1. busy never rises.
- Back-to-back: a new mult/div can start in cycle T+N+1, the first cycle with busy=0.
- The pipeline never issues start in the same cycle that reset is released, so that case needs no special handling.

## Structure

- md_op codes (MD_MULT=0 .. MD_MTLO=5) and MD_CNT_W=4 are added to the shared define.v beside the existing Tuse/RES constants.
- Sub-module md_arith: purely combinational 64-bit product and quotient/remainder for all four signed/unsigned ops, including the zero and overflow cases. md_unit holds the counter, HI/LO and the stall logic.

## Test plan

- MULT rs=0xFFFFFFFE (-2), rt=3: busy for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with rs=rt=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001 at T+6.
- DIV cases, each with busy for 10 cycles:
  - -7/2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - 0x80000000/-1 gives LO=0x80000000, HI=0.
  - 5/0 leaves HI/LO unchanged.
- MTHI 0x1234 while idle: busy stays 0, and rd_sel=1 reads 0x1234 next cycle. Then start DIVU with d_is_md=1 held: md_stall is high cycles T..T+10 and low at T+11.
- Assert reset at T+3 of a DIV: busy=0 and HI=LO=0 immediately. A MULT issued after reset completes normally.
- d_is_md=0 (ALU instruction) during busy: md_stall stays 0.
